// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the shifter datapath: the 2-bit operation type and
// its encodings. Also used by the fixed shift-by-2 unit and the ALU decode.
// -----------------------------------------------------------------------------
package shifter_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ROL = 2'd0;
    localparam op_t OP_SLL = 2'd1;
    localparam op_t OP_ROR = 2'd2;
    localparam op_t OP_SRA = 2'd3;

endpackage

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// One combinational stage of the barrel shifter: shifts data_i by DIST bit
// positions under op_i when en_i is set, otherwise passes data_i through.
//   data_i  WIDTH  stage input
//   op_i    2      ROL / SLL / ROR / SRA
//   en_i    1      apply the shift (shift-amount bit for this stage)
//   data_o  WIDTH  stage output
// DIST is always below WIDTH (at most WIDTH/2 in the pipe).
// -----------------------------------------------------------------------------
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  op_t              op_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                OP_ROL:  data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
                OP_SLL:  data_o = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
                OP_ROR:  data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
                default: data_o = {{DIST{data_i[WIDTH-1]}}, data_i[WIDTH-1:DIST]};
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// -----------------------------------------------------------------------------
// shifter_pipe
// Pipelined barrel shifter, one log2 stage registered per cycle, with
// valid/ready handshakes on both sides.
//   clk, rst_n           clock, async active-low reset
//   flush                synchronous clear of all in-flight beats
//   in_valid / in_ready  input handshake
//   in_data, in_op,      value to shift, operation, shift amount
//   in_shamt
//   out_valid/out_ready  output handshake
//   out_data             shifted result (last stage register)
// -----------------------------------------------------------------------------
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = 16,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  op_t                in_op,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    localparam int S = SHAMT_W;

    logic               v_q    [S];
    logic [WIDTH-1:0]   d_q    [S];
    op_t                op_q   [S];
    logic [SHAMT_W-1:0] sh_q   [S];

    // Inputs seen by each stage (external port for stage 0, previous stage
    // registers otherwise) and the shifted value each stage would load.
    logic               up_v    [S];
    logic [WIDTH-1:0]   up_data [S];
    op_t                up_op   [S];
    logic [SHAMT_W-1:0] up_sh   [S];
    logic [WIDTH-1:0]   data_d  [S];
    logic               rdy     [S+1];

    always_comb begin
        up_v[0]    = in_valid;
        up_data[0] = in_data;
        up_op[0]   = in_op;
        up_sh[0]   = in_shamt;
        for (int k = 1; k < S; k++) begin
            up_v[k]    = v_q[k-1];
            up_data[k] = d_q[k-1];
            up_op[k]   = op_q[k-1];
            up_sh[k]   = sh_q[k-1];
        end
        // A stage can load if it is empty or its contents move on this cycle.
        rdy[S] = out_ready;
        for (int k = S - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data_i (up_data[k]),
            .op_i   (up_op[k]),
            .en_i   (up_sh[k][k]),
            .data_o (data_d[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < S; k++) begin
                v_q[k]  <= 1'b0;
                d_q[k]  <= '0;
                op_q[k] <= OP_ROL;
                sh_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < S; k++) begin
                if (flush) begin
                    v_q[k] <= 1'b0;
                end else if (rdy[k]) begin
                    v_q[k]  <= up_v[k];
                    d_q[k]  <= data_d[k];
                    op_q[k] <= up_op[k];
                    sh_q[k] <= up_sh[k];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[S-1];
    assign out_data  = d_q[S-1];

endmodule
